matmul_seq: RTL
===============

# matmul_seq

Parametrised, resource-shared matrix-multiply engine for the neural-net datapath. It computes O = act(A·B + bias) on IEEE-754 single-precision operands using one `mul_float` and one `add_float` instance, reused element by element. It replaces the fully parallel multiplier/adder-tree array for layers where area matters more than latency. It adds optional per-column bias, optional ReLU, sticky exception flags and a busy/done handshake.

## Interface
- `S`, 32 — float width; passed to `mul_float`/`add_float` as `FLOAT_WIDTH`.
- `H`, 2 — rows of A and O.
- `C`, 2 — common dimension (cols of A, rows of B); C ≥ 1.
- `W`, 2 — cols of B and O.
- `clk`  in  1  — single clock; all state on posedge.
- `rst_n`  in  1  — asynchronous, active-low reset. Also drives `rst_n` of both sub-units.
- `start`  in  1  — one-cycle request; sampled only when `busy`=0.
- `bias_en`  in  1  — add `bias[c]` to each output column; latched at start.
- `relu_en`  in  1  — apply ReLU to each result; latched at start.
- `a`  in  S*H*C  — A, row-major.
- `b`  in  S*C*W  — B, row-major.
- `bias`  in  S*W  — bias vector.
- `o`  out  S*H*W  — O, row-major, registered.
- `busy`  out  1  — high from the cycle after start is accepted until done.
- `done`  out  1  — level; high after completion until next accepted start.
- `nan_flag`, `ovf_flag`  out  1 each — sticky OR of sub-unit nan/overflow over the current job.

## Operation
- Packing for all buses: element (r,c) of an R×K matrix occupies bits [S*(R*K−r*K−c)−1 -: S]. Element (0,0) is at the MSB. Output is NOT transposed.
- On accepted start, the block latches `a`, `b`, `bias`, `bias_en` and `relu_en` into internal registers. It then clears `done`, `nan_flag` and `ovf_flag`, and sets `busy`.
- Iteration order: i outer (0..H−1), j (0..W−1), k inner (0..C−1).
- States:
  - IDLE: wait for start.
  - MUL_GO: pulse mul start 1 cycle with A[i][k] and B[k][j].
  - MUL_WAIT: wait for mul done. At k=0, acc ← product and go to the next k, or to BIAS/ACT if C=1. Otherwise go to ADD_GO.
  - ADD_GO / ADD_WAIT: acc ← acc + product. Then go to the next k, or to BIAS when k=C−1.
  - BIAS_GO / BIAS_WAIT: only if `bias_en`. acc ← acc + bias[j].
  - WRITE: write act(acc) to o(i,j), then advance j, then i.
  - After the last element, go to IDLE with done=1 and busy=0.
- Sub-unit handshake: start is held high for exactly one cycle. The result is sampled in the first cycle the unit's done is seen high. Operand inputs are held stable from GO until the result is sampled.
- No add with 0.0 is issued for k=0. This keeps −0.0 products intact.
- ReLU: if sign bit=1 and the value is not NaN (exponent all ones with nonzero mantissa), the result becomes 0x00000000; this includes −0.0. NaN passes unchanged.
- Flags: each sub-unit's nan/overflow outputs are OR'd into the flags in the cycle its result is sampled.
- `start` while `busy`=1 is ignored: no relatch, outputs unaffected.
- `o` is updated only in WRITE. Elements not yet written keep their previous-job values until overwritten.

## Timing
- Reset (async assert): state=IDLE, o=0, busy=0, done=0, nan_flag=0, ovf_flag=0, all counters=0, both sub-units held in reset. Reset may assert mid-job; the job is abandoned and no partial state survives.
- Deassertion is synchronous-safe: the first accepted start can occur on the first posedge with rst_n=1.
- Let Lm and La be the cycles from sub-unit start pulse to done-seen. Let Bn = bias_en.
- Per element: C·(1+Lm) + (C−1+Bn)·(1+La) + 1 cycles.
- Total: start sampled at cycle 0, busy=1 at cycle 1, done=1 at cycle 1 + H·W·(per-element).
- done rises and busy falls on the same edge. A new start is accepted on that same cycle's following edge.
- Back-to-back: start asserted in the cycle done first reads 1 is accepted; done drops the next cycle.

## Test plan
- H=C=W=2, A=identity (0x3F800000 diagonal, 0 elsewhere), B=[1,2;3,4] → o = {0x3F800000, 0x40000000, 0x40400000, 0x40800000} MSB-first. Flags 0. Latency matches the formula.
- H=W=1, C=2, A=[1.0, 2.0], B=[3.0; 4.0] → o=0x41300000 (11.0). Then bias_en=1, bias=0xBF800000 → o=0x41200000 (10.0).
- H=C=W=1, A=1.0, B=0xC0000000 (−2.0): relu_en=0 → 0xC0000000; relu_en=1 → 0x00000000. A=0x7FC00000 (NaN), relu_en=1 → 0x7FC00000 with nan_flag=1.
- Overflow: A=0x7F000000, B=0x40000000, C=1 → ovf_flag=1 sticky until next start.
- Start pulse mid-job with different `a` → ignored; final o reflects the first job's operands.
- rst_n low for 1 cycle mid-job → o=0, busy=0, done=0 immediately (async). A subsequent start completes a correct job.

Source files
------------

// File: rtl/matmul_seq.sv
// matmul_seq: float32 O = act(A*B + bias), computed one element at a time.
// A single multiplier and a single adder are shared across every element.

module mul_float #(
  parameter int FLOAT_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [FLOAT_WIDTH-1:0] a,
  input  logic [FLOAT_WIDTH-1:0] b,
  output logic [FLOAT_WIDTH-1:0] result,
  output logic                   done,
  output logic                   nan,
  output logic                   overflow
);
  logic        w_sa, w_sb, w_s;
  logic [7:0]  w_ea, w_eb;
  logic [22:0] w_ma, w_mb, w_mant;
  logic        w_za, w_zb, w_ia, w_ib, w_na, w_nb;
  logic [47:0] w_p;
  logic [23:0] w_m;
  logic        w_g, w_st, w_inc;
  logic [24:0] w_mr;
  logic signed [9:0] w_e;
  logic [31:0] w_res;
  logic        w_nan, w_ovf;

  always_comb begin
    {w_sa, w_ea, w_ma} = a;
    {w_sb, w_eb, w_mb} = b;
    w_s  = w_sa ^ w_sb;
    w_za = (w_ea == 8'h00);
    w_zb = (w_eb == 8'h00);
    w_ia = (w_ea == 8'hFF) && (w_ma == '0);
    w_ib = (w_eb == 8'hFF) && (w_mb == '0);
    w_na = (w_ea == 8'hFF) && (w_ma != '0);
    w_nb = (w_eb == 8'hFF) && (w_mb != '0);
    w_p  = 48'({1'b1, w_ma}) * 48'({1'b1, w_mb});
    if (w_p[47]) begin
      w_m  = w_p[47:24];
      w_g  = w_p[23];
      w_st = |w_p[22:0];
    end else begin
      w_m  = w_p[46:23];
      w_g  = w_p[22];
      w_st = |w_p[21:0];
    end
    // round to nearest, ties to even
    w_inc  = w_g & (w_st | w_m[0]);
    w_mr   = {1'b0, w_m} + 25'(w_inc);
    w_mant = w_mr[24] ? w_mr[23:1] : w_mr[22:0];
    w_e    = 10'(w_ea) + 10'(w_eb) - 10'd127
           + 10'(w_p[47]) + 10'(w_mr[24]);
    w_nan  = 1'b0;
    w_ovf  = 1'b0;
    if (w_na || w_nb || (w_ia && w_zb) || (w_ib && w_za)) begin
      w_res = 32'h7FC0_0000;
      w_nan = 1'b1;
    end else if (w_ia || w_ib) begin
      w_res = {w_s, 8'hFF, 23'h0};
    end else if (w_za || w_zb) begin
      w_res = {w_s, 31'h0};
    end else if (w_e >= 10'sd255) begin
      w_res = {w_s, 8'hFF, 23'h0};
      w_ovf = 1'b1;
    end else if (w_e <= 10'sd0) begin
      w_res = {w_s, 31'h0};
    end else begin
      w_res = {w_s, w_e[7:0], w_mant};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result   <= '0;
      done     <= 1'b0;
      nan      <= 1'b0;
      overflow <= 1'b0;
    end else begin
      done <= start;
      if (start) begin
        result   <= w_res;
        nan      <= w_nan;
        overflow <= w_ovf;
      end
    end
  end
endmodule

module add_float #(
  parameter int FLOAT_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [FLOAT_WIDTH-1:0] a,
  input  logic [FLOAT_WIDTH-1:0] b,
  output logic [FLOAT_WIDTH-1:0] result,
  output logic                   done,
  output logic                   nan,
  output logic                   overflow
);
  logic        w_sa, w_sb, w_sx, w_sy, w_swap, w_sub;
  logic [7:0]  w_ea, w_eb, w_ex, w_ey, w_d;
  logic [22:0] w_ma, w_mb, w_mx, w_my, w_mant;
  logic        w_za, w_zb, w_ia, w_ib, w_na, w_nb;
  logic [52:0] w_yw;
  logic [26:0] w_x, w_y, w_n;
  logic [27:0] w_r;
  logic [4:0]  w_lz;
  logic        w_inc;
  logic [24:0] w_mr;
  logic signed [9:0] w_e;
  logic [31:0] w_res;
  logic        w_nan, w_ovf;

  function automatic logic [4:0] f_lzc(input logic [26:0] v);
    logic [4:0] n;
    logic       f;
    n = 5'd0;
    f = 1'b0;
    for (int i = 26; i >= 0; i--) begin
      if (v[i]) f = 1'b1;
      else if (!f) n = n + 5'd1;
    end
    return n;
  endfunction

  always_comb begin
    {w_sa, w_ea, w_ma} = a;
    {w_sb, w_eb, w_mb} = b;
    w_za = (w_ea == 8'h00);
    w_zb = (w_eb == 8'h00);
    w_ia = (w_ea == 8'hFF) && (w_ma == '0);
    w_ib = (w_eb == 8'hFF) && (w_mb == '0);
    w_na = (w_ea == 8'hFF) && (w_ma != '0);
    w_nb = (w_eb == 8'hFF) && (w_mb != '0);
    // x is the larger magnitude, so a subtract never goes negative
    w_swap = {w_eb, w_mb} > {w_ea, w_ma};
    {w_sx, w_ex, w_mx} = w_swap ? b : a;
    {w_sy, w_ey, w_my} = w_swap ? a : b;
    w_d  = w_ex - w_ey;
    w_yw = {1'b1, w_my, 29'h0} >> w_d;
    w_y  = (w_d > 8'd26) ? 27'd1 : {w_yw[52:27], |w_yw[26:0]};
    w_x  = {1'b1, w_mx, 3'b000};
    w_sub = w_sx ^ w_sy;
    w_r  = w_sub ? ({1'b0, w_x} - {1'b0, w_y})
                 : ({1'b0, w_x} + {1'b0, w_y});
    w_lz = f_lzc(w_r[26:0]);
    if (w_r[27]) begin
      w_n = {w_r[27:2], w_r[1] | w_r[0]};
      w_e = 10'(w_ex) + 10'd1;
    end else begin
      w_n = w_r[26:0] << w_lz;
      w_e = 10'(w_ex) - 10'(w_lz);
    end
    w_inc  = w_n[2] & ((|w_n[1:0]) | w_n[3]);
    w_mr   = {1'b0, w_n[26:3]} + 25'(w_inc);
    w_mant = w_mr[24] ? w_mr[23:1] : w_mr[22:0];
    if (w_mr[24]) w_e = w_e + 10'sd1;
    w_nan = 1'b0;
    w_ovf = 1'b0;
    if (w_na || w_nb || (w_ia && w_ib && (w_sa != w_sb))) begin
      w_res = 32'h7FC0_0000;
      w_nan = 1'b1;
    end else if (w_ia || w_ib) begin
      w_res = {(w_ia ? w_sa : w_sb), 8'hFF, 23'h0};
    end else if (w_za && w_zb) begin
      w_res = {w_sa & w_sb, 31'h0};
    end else if (w_za) begin
      w_res = b;
    end else if (w_zb) begin
      w_res = a;
    end else if (w_r == '0) begin
      w_res = 32'h0;
    end else if (w_e >= 10'sd255) begin
      w_res = {w_sx, 8'hFF, 23'h0};
      w_ovf = 1'b1;
    end else if (w_e <= 10'sd0) begin
      w_res = {w_sx, 31'h0};
    end else begin
      w_res = {w_sx, w_e[7:0], w_mant};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result   <= '0;
      done     <= 1'b0;
      nan      <= 1'b0;
      overflow <= 1'b0;
    end else begin
      done <= start;
      if (start) begin
        result   <= w_res;
        nan      <= w_nan;
        overflow <= w_ovf;
      end
    end
  end
endmodule

module matmul_seq #(
  parameter int S = 32,
  parameter int H = 2,
  parameter int C = 2,
  parameter int W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             bias_en,
  input  logic             relu_en,
  input  logic [S*H*C-1:0] a,
  input  logic [S*C*W-1:0] b,
  input  logic [S*W-1:0]   bias,
  output logic [S*H*W-1:0] o,
  output logic             busy,
  output logic             done,
  output logic             nan_flag,
  output logic             ovf_flag
);
  localparam int IW = (H > 1) ? $clog2(H) : 1;
  localparam int JW = (W > 1) ? $clog2(W) : 1;
  localparam int KW = (C > 1) ? $clog2(C) : 1;
  localparam int HP = 1 << IW;
  localparam int WP = 1 << JW;
  localparam int CP = 1 << KW;

  typedef enum logic [2:0] {
    S_IDLE, S_MUL_GO, S_MUL_WAIT, S_ADD_GO,
    S_ADD_WAIT, S_BIAS_GO, S_BIAS_WAIT, S_WRITE
  } state_t;

  state_t r_state, w_nxt, w_post;

  logic [S*H*C-1:0] r_a;
  logic [S*C*W-1:0] r_b;
  logic [S*W-1:0]   r_bias;
  logic             r_bias_en, r_relu_en;
  logic [IW-1:0]    r_i;
  logic [JW-1:0]    r_j;
  logic [KW-1:0]    r_k;
  logic [S-1:0]     r_acc, r_prod;
  logic [S-1:0]     r_om [HP][WP];
  logic             r_busy, r_done, r_nan, r_ovf;

  // power-of-two padded views so counters index them at full width
  logic [S-1:0] w_am [HP][CP];
  logic [S-1:0] w_bm [CP][WP];
  logic [S-1:0] w_bv [WP];

  logic         w_mul_go, w_add_go, w_last_k, w_last_e;
  logic [S-1:0] w_mul_a, w_mul_b, w_add_a, w_add_b;
  logic [S-1:0] w_mul_res, w_add_res;
  logic         w_mul_done, w_mul_nan, w_mul_ovf;
  logic         w_add_done, w_add_nan, w_add_ovf;

  for (genvar gi = 0; gi < HP; gi++) begin : g_ar
    for (genvar gk = 0; gk < CP; gk++) begin : g_ac
      if (gi < H && gk < C) begin : g_v
        assign w_am[gi][gk] = r_a[S*(H*C-gi*C-gk)-1 -: S];
      end else begin : g_z
        assign w_am[gi][gk] = '0;
      end
    end
  end

  for (genvar gk = 0; gk < CP; gk++) begin : g_br
    for (genvar gj = 0; gj < WP; gj++) begin : g_bc
      if (gk < C && gj < W) begin : g_v
        assign w_bm[gk][gj] = r_b[S*(C*W-gk*W-gj)-1 -: S];
      end else begin : g_z
        assign w_bm[gk][gj] = '0;
      end
    end
  end

  for (genvar gj = 0; gj < WP; gj++) begin : g_bv
    if (gj < W) begin : g_v
      assign w_bv[gj] = r_bias[S*(W-gj)-1 -: S];
    end else begin : g_z
      assign w_bv[gj] = '0;
    end
  end

  for (genvar gi = 0; gi < H; gi++) begin : g_or
    for (genvar gj = 0; gj < W; gj++) begin : g_oc
      assign o[S*(H*W-gi*W-gj)-1 -: S] = r_om[gi][gj];
    end
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign nan_flag = r_nan;
  assign ovf_flag = r_ovf;

  assign w_mul_a = w_am[r_i][r_k];
  assign w_mul_b = w_bm[r_k][r_j];
  assign w_add_a = r_acc;
  assign w_add_b = (r_state == S_BIAS_GO || r_state == S_BIAS_WAIT)
                 ? w_bv[r_j] : r_prod;

  function automatic logic [S-1:0] f_relu(input logic [S-1:0] v,
                                           input logic en);
    logic is_nan;
    is_nan = (v[30:23] == 8'hFF) && (v[22:0] != '0);
    return (en && v[31] && !is_nan) ? '0 : v;
  endfunction

  always_comb begin
    w_nxt    = r_state;
    w_mul_go = 1'b0;
    w_add_go = 1'b0;
    w_last_k = (r_k == KW'(C-1));
    w_last_e = (r_i == IW'(H-1)) && (r_j == JW'(W-1));
    w_post   = r_bias_en ? S_BIAS_GO : S_WRITE;
    unique case (r_state)
      S_IDLE:     if (start) w_nxt = S_MUL_GO;
      S_MUL_GO: begin
        w_mul_go = 1'b1;
        w_nxt    = S_MUL_WAIT;
      end
      S_MUL_WAIT: if (w_mul_done) begin
        if (r_k != '0)     w_nxt = S_ADD_GO;
        else if (w_last_k) w_nxt = w_post;
        else               w_nxt = S_MUL_GO;
      end
      S_ADD_GO: begin
        w_add_go = 1'b1;
        w_nxt    = S_ADD_WAIT;
      end
      S_ADD_WAIT: if (w_add_done) w_nxt = w_last_k ? w_post : S_MUL_GO;
      S_BIAS_GO: begin
        w_add_go = 1'b1;
        w_nxt    = S_BIAS_WAIT;
      end
      S_BIAS_WAIT: if (w_add_done) w_nxt = S_WRITE;
      S_WRITE:     w_nxt = w_last_e ? S_IDLE : S_MUL_GO;
      default:     w_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_a       <= '0;
      r_b       <= '0;
      r_bias    <= '0;
      r_bias_en <= 1'b0;
      r_relu_en <= 1'b0;
      r_i       <= '0;
      r_j       <= '0;
      r_k       <= '0;
      r_acc     <= '0;
      r_prod    <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_nan     <= 1'b0;
      r_ovf     <= 1'b0;
      for (int x = 0; x < HP; x++)
        for (int y = 0; y < WP; y++)
          r_om[x][y] <= '0;
    end else begin
      r_state <= w_nxt;
      unique case (r_state)
        S_IDLE: if (start) begin
          r_a       <= a;
          r_b       <= b;
          r_bias    <= bias;
          r_bias_en <= bias_en;
          r_relu_en <= relu_en;
          r_i       <= '0;
          r_j       <= '0;
          r_k       <= '0;
          r_busy    <= 1'b1;
          r_done    <= 1'b0;
          r_nan     <= 1'b0;
          r_ovf     <= 1'b0;
        end
        S_MUL_WAIT: if (w_mul_done) begin
          r_nan <= r_nan | w_mul_nan;
          r_ovf <= r_ovf | w_mul_ovf;
          // first product seeds acc directly, keeping -0.0 intact
          if (r_k == '0) begin
            r_acc <= w_mul_res;
            if (!w_last_k) r_k <= r_k + KW'(1);
          end else begin
            r_prod <= w_mul_res;
          end
        end
        S_ADD_WAIT: if (w_add_done) begin
          r_nan <= r_nan | w_add_nan;
          r_ovf <= r_ovf | w_add_ovf;
          r_acc <= w_add_res;
          if (!w_last_k) r_k <= r_k + KW'(1);
        end
        S_BIAS_WAIT: if (w_add_done) begin
          r_nan <= r_nan | w_add_nan;
          r_ovf <= r_ovf | w_add_ovf;
          r_acc <= w_add_res;
        end
        S_WRITE: begin
          r_om[r_i][r_j] <= f_relu(r_acc, r_relu_en);
          r_k <= '0;
          if (w_last_e) begin
            r_busy <= 1'b0;
            r_done <= 1'b1;
            r_i    <= '0;
            r_j    <= '0;
          end else if (r_j == JW'(W-1)) begin
            r_j <= '0;
            r_i <= r_i + IW'(1);
          end else begin
            r_j <= r_j + JW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  mul_float #(.FLOAT_WIDTH(S)) u_mul (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (w_mul_go),
    .a        (w_mul_a),
    .b        (w_mul_b),
    .result   (w_mul_res),
    .done     (w_mul_done),
    .nan      (w_mul_nan),
    .overflow (w_mul_ovf)
  );

  add_float #(.FLOAT_WIDTH(S)) u_add (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (w_add_go),
    .a        (w_add_a),
    .b        (w_add_b),
    .result   (w_add_res),
    .done     (w_add_done),
    .nan      (w_add_nan),
    .overflow (w_add_ovf)
  );
endmodule
